// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS frequency-sweep sequencer.
package dds_pkg;

    localparam int KW = 32;
    localparam int PW = 11;
    localparam int DW = 16;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    // The reserved encoding 3 behaves as a single-up sweep.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_SAW;
            2'd2:    return MODE_TRI;
            default: return MODE_SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell timer: pulses expire on the last of max(load,1) enabled cycles, then restarts.
module dds_dwell_timer #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] load,
    input  logic          clear,
    input  logic          en,
    output logic          expire
);

    logic [DW-1:0] cnt;
    logic [DW-1:0] last;

    // A dwell of 0 is held for one cycle, the same as a dwell of 1.
    assign last   = (load == '0) ? '0 : load - DW'(1);
    assign expire = en && !clear && (cnt == last);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (en)
            cnt <= expire ? '0 : cnt + DW'(1);
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS sweep sequencer driving K/P from a registered start/stop/step/dwell config.
// Optional macro DDS_SWEEP_CNT_EN adds the saturating sweep_cnt output.
module dds_sweep_ctrl #(
    parameter int KW = dds_pkg::KW,
    parameter int PW = dds_pkg::PW,
    parameter int DW = dds_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [KW-1:0] cfg_k_start,
    input  logic [KW-1:0] cfg_k_stop,
    input  logic [KW-1:0] cfg_k_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [1:0]    cfg_mode,
    input  logic [PW-1:0] cfg_phase,
    input  logic          start,
    input  logic          abort,
    output logic [KW-1:0] k_out,
    output logic [PW-1:0] p_out,
    output logic          busy,
    output logic          done,
    output logic          wrap,
    output logic          err
`ifdef DDS_SWEEP_CNT_EN
  , output logic [15:0]   sweep_cnt
`endif
);

    import dds_pkg::*;

    logic [KW-1:0] k_start_r, k_stop_r, k_step_r;
    logic [DW-1:0] dwell_r;
    logic [PW-1:0] phase_r;
    mode_e         mode_r;
    state_e        state;

    logic [KW:0]   up_sum, dn_diff;
    logic          up_ok, dn_ok, up_refl_ok, dn_refl_ok, start_ok, turn, expire;

    assign cfg_ready = !busy;

    dds_dwell_timer #(.DW(DW)) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (dwell_r),
        .clear  ((state == ST_IDLE) || abort),
        .en     (state != ST_IDLE),
        .expire (expire)
    );

    // NOTE: every always_comb output is assigned before any branch, so no latch can be inferred.
    always_comb begin
        up_sum     = {1'b0, k_out} + {1'b0, k_step_r};
        dn_diff    = {1'b0, k_out} - {1'b0, k_step_r};
        // A zero step never counts as progress, so a sweep with step 0 turns every dwell.
        up_ok      = !up_sum[KW] && (up_sum[KW-1:0] <= k_stop_r) && (k_step_r != '0);
        dn_ok      = !dn_diff[KW] && (dn_diff[KW-1:0] >= k_start_r) && (k_step_r != '0);
        up_refl_ok = !dn_diff[KW] && (dn_diff[KW-1:0] >= k_start_r) && (dn_diff[KW-1:0] <= k_stop_r);
        dn_refl_ok = !up_sum[KW] && (up_sum[KW-1:0] >= k_start_r) && (up_sum[KW-1:0] <= k_stop_r);
        start_ok   = (k_start_r <= k_stop_r);
        turn       = expire && (((state == ST_UP) && !up_ok) || ((state == ST_DOWN) && !dn_ok));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_start_r <= '0;
            k_stop_r  <= '0;
            k_step_r  <= '0;
            dwell_r   <= '0;
            phase_r   <= '0;
            mode_r    <= MODE_SINGLE;
            state     <= ST_IDLE;
            k_out     <= '0;
            p_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            err  <= 1'b0;

            if (cfg_valid && !busy) begin
                k_start_r <= cfg_k_start;
                k_stop_r  <= cfg_k_stop;
                k_step_r  <= cfg_k_step;
                dwell_r   <= cfg_dwell;
                phase_r   <= cfg_phase;
                mode_r    <= decode_mode(cfg_mode);
            end

            if (abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                k_out <= '0;
                p_out <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (!start_ok) begin
                                err <= 1'b1;
                            end else begin
                                state <= ST_UP;
                                busy  <= 1'b1;
                                k_out <= k_start_r;
                                p_out <= phase_r;
                            end
                        end
                    end
                    ST_UP: begin
                        if (turn) begin
                            case (mode_r)
                                MODE_SAW: begin
                                    k_out <= k_start_r;
                                    wrap  <= 1'b1;
                                end
                                MODE_TRI: begin
                                    state <= ST_DOWN;
                                    wrap  <= 1'b1;
                                    if (up_refl_ok)
                                        k_out <= dn_diff[KW-1:0];
                                end
                                default: begin
                                    state <= ST_IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            endcase
                        end else if (expire) begin
                            k_out <= up_sum[KW-1:0];
                        end
                    end
                    ST_DOWN: begin
                        // Only a triangle sweep ever runs downward.
                        if (turn) begin
                            state <= ST_UP;
                            wrap  <= 1'b1;
                            if (dn_refl_ok)
                                k_out <= up_sum[KW-1:0];
                        end else if (expire) begin
                            k_out <= dn_diff[KW-1:0];
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef DDS_SWEEP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sweep_cnt <= '0;
        else if (!abort && (state == ST_IDLE) && start && start_ok)
            sweep_cnt <= '0;
        else if (!abort && turn && (sweep_cnt != 16'hFFFF))
            sweep_cnt <= sweep_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: an index-walking sweep model fills a queue, a monitor drains it.
module tb_dds_sweep_ctrl;

    localparam int KW = 32;
    localparam int PW = 11;
    localparam int DW = 16;

    logic          clk, rst_n;
    logic          cfg_valid, cfg_ready;
    logic [KW-1:0] cfg_k_start, cfg_k_stop, cfg_k_step;
    logic [DW-1:0] cfg_dwell;
    logic [1:0]    cfg_mode;
    logic [PW-1:0] cfg_phase;
    logic          start, abort;
    logic [KW-1:0] k_out;
    logic [PW-1:0] p_out;
    logic          busy, done, wrap, err;
`ifdef DDS_SWEEP_CNT_EN
    logic [15:0]   sweep_cnt;
`endif

    dds_sweep_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_k_start (cfg_k_start),
        .cfg_k_stop  (cfg_k_stop),
        .cfg_k_step  (cfg_k_step),
        .cfg_dwell   (cfg_dwell),
        .cfg_mode    (cfg_mode),
        .cfg_phase   (cfg_phase),
        .start       (start),
        .abort       (abort),
        .k_out       (k_out),
        .p_out       (p_out),
        .busy        (busy),
        .done        (done),
        .wrap        (wrap),
        .err         (err)
`ifdef DDS_SWEEP_CNT_EN
      , .sweep_cnt   (sweep_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [KW-1:0] k;
        logic [PW-1:0] p;
        logic          busy;
        logic          done;
        logic          wrap;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [KW-1:0] cur_k    = '0;
    logic [PW-1:0] cur_p    = '0;
    int            exp_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT shows activity it must match the next expected entry.
    always @(negedge clk) begin
        exp_t act;
        if (rst_n && (busy || done || wrap || err)) begin
            act = {k_out, p_out, busy, done, wrap, err};
            if (exp_q.size() == 0)
                check("unexpected_output", 64'(act), 64'd0);
            else
                check("sweep_seq", 64'(act), 64'(exp_q.pop_front()));
        end
    end

    // Reference: list the distinct K values, then walk an index over them per mode.
    task automatic model(input logic [KW-1:0] ks, input logic [KW-1:0] ke, input logic [KW-1:0] stp,
                         input logic [DW-1:0] dw, input logic [1:0] md, input logic [PW-1:0] ph,
                         input int limit, output bit ended_done);
        longint vals[$];
        longint v;
        int     n, idx, d_cyc, emitted, m;
        bit     up, wp;
        ended_done = 0;
        v = longint'(ks);
        vals.push_back(v);
        if (stp != 0) begin
            v = v + longint'(stp);
            while (v <= longint'(ke)) begin
                vals.push_back(v);
                v = v + longint'(stp);
            end
        end
        n = vals.size();
        d_cyc = (dw == 0) ? 1 : int'(dw);
        m = (md == 2'd3) ? 0 : int'(md);
        idx = 0; up = 1; wp = 0; emitted = 0; exp_cnt = 0;
        while (1) begin
            for (int d = 0; d < d_cyc; d++) begin
                exp_q.push_back({KW'(vals[idx]), ph, 1'b1, 1'b0, (d == 0) && wp, 1'b0});
                if (d == 0 && wp && exp_cnt < 65535) exp_cnt++;
                wp = 0;
                emitted++;
                if (emitted == limit) return;
            end
            if (m == 0) begin
                if (idx + 1 < n) idx++;
                else begin
                    exp_q.push_back({KW'(vals[idx]), ph, 1'b0, 1'b1, 1'b0, 1'b0});
                    if (exp_cnt < 65535) exp_cnt++;
                    ended_done = 1;
                    cur_k = KW'(vals[idx]);
                    cur_p = ph;
                    return;
                end
            end else if (m == 1) begin
                if (idx + 1 < n) idx++;
                else begin idx = 0; wp = 1; end
            end else if (up) begin
                if (idx + 1 < n) idx++;
                else begin up = 0; wp = 1; if (n > 1) idx--; end
            end else begin
                if (idx > 0) idx--;
                else begin up = 1; wp = 1; if (n > 1) idx++; end
            end
        end
    endtask

    // limit 0 runs a single-up sweep to completion; otherwise abort after limit cycles.
    task automatic run(input logic [KW-1:0] ks, input logic [KW-1:0] ke, input logic [KW-1:0] stp,
                       input logic [DW-1:0] dw, input logic [1:0] md, input logic [PW-1:0] ph,
                       input int limit, input bit poke, input bit abort_with_start);
        bit ended_done;
        int n;
        @(posedge clk); #1;
        cfg_k_start = ks; cfg_k_stop = ke; cfg_k_step = stp;
        cfg_dwell = dw; cfg_mode = md; cfg_phase = ph; cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        if (ks > ke) begin
            exp_q.push_back({cur_k, cur_p, 1'b0, 1'b0, 1'b0, 1'b1});
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            check("err_drained", 64'(exp_q.size()), 64'd0);
            check("err_not_busy", 64'(busy), 64'd0);
            return;
        end
        model(ks, ke, stp, dw, md, ph, (limit == 0) ? (1 << 30) : limit, ended_done);
        n = exp_q.size();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < (ended_done ? n + 2 : n - 1); i++) begin
            @(posedge clk); #1;
            cfg_valid = poke && (i + 2 < n);
            if (cfg_valid) begin
                cfg_k_start = $urandom; cfg_k_stop = $urandom; cfg_k_step = $urandom;
                cfg_dwell = DW'($urandom); cfg_mode = 2'($urandom); cfg_phase = PW'($urandom);
                check("cfg_ready_busy", 64'(cfg_ready), 64'd0);
            end
        end
        cfg_valid = 1'b0;
        if (!ended_done) begin
            abort = 1'b1;
            start = abort_with_start;
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            @(negedge clk);
            check("abort_outputs", 64'({k_out, p_out, busy, cfg_ready}), 64'({{KW{1'b0}}, {PW{1'b0}}, 1'b0, 1'b1}));
            cur_k = '0;
            cur_p = '0;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef DDS_SWEEP_CNT_EN
        check("sweep_cnt", 64'(sweep_cnt), 64'(exp_cnt));
`endif
    endtask

    initial begin
        logic [KW-1:0] ks, ke;
        bit            unused_done;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [KW-1:0] ks;
        bit            dummy;
        rst_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_k_start = '0; cfg_k_stop = '0; cfg_k_step = '0;
        cfg_dwell = '0; cfg_mode = '0; cfg_phase = '0;
        #12;
        check("reset_outputs", 64'({k_out, p_out, busy, done, wrap, err, cfg_ready}),
              64'({{KW{1'b0}}, {PW{1'b0}}, 5'b00001}));
        #11 rst_n = 1'b1;

        run(32'd100, 32'd400, 32'd100, 16'd3, 2'd0, 11'd5, 0, 1'b1, 1'b0);
        run(32'd0, 32'd250, 32'd100, 16'd1, 2'd1, 11'd7, 12, 1'b0, 1'b0);
        run(32'd10, 32'd30, 32'd10, 16'd2, 2'd2, 11'd9, 23, 1'b1, 1'b0);
        run(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 16'd1, 2'd0, 11'd1, 0, 1'b0, 1'b0);
        run(32'd100, 32'd400, 32'd100, 16'd3, 2'd0, 11'd3, 5, 1'b0, 1'b1);
        run(32'd100, 32'd400, 32'd100, 16'd3, 2'd0, 11'd3, 0, 1'b0, 1'b0);
        run(32'd500, 32'd100, 32'd10, 16'd1, 2'd0, 11'd2, 0, 1'b0, 1'b0);
        run(32'd42, 32'd99, 32'd0, 16'd2, 2'd0, 11'd4, 0, 1'b0, 1'b0);
        run(32'd42, 32'd99, 32'd0, 16'd2, 2'd2, 11'd4, 9, 1'b0, 1'b0);
        run(32'd20, 32'd20, 32'd5, 16'd0, 2'd3, 11'd6, 0, 1'b0, 1'b0);

        for (int t = 0; t < 14; t++) begin
            logic [1:0] md;
            ks = KW'($urandom_range(0, 1000));
            md = 2'($urandom_range(0, 3));
            run(ks, ks + KW'($urandom_range(0, 200)), KW'($urandom_range(0, 80)),
                DW'($urandom_range(0, 3)), md, PW'($urandom),
                (md == 2'd1 || md == 2'd2) ? int'($urandom_range(10, 40)) :
                    (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset in the middle of a running sweep.
        @(posedge clk); #1;
        cfg_k_start = 32'd5; cfg_k_stop = 32'd50; cfg_k_step = 32'd5;
        cfg_dwell = 16'd1; cfg_mode = 2'd1; cfg_phase = 11'd77; cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        model(32'd5, 32'd50, 32'd5, 16'd1, 2'd1, 11'd77, 64, dummy);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset", 64'({k_out, p_out, busy, done, wrap, err, cfg_ready}),
              64'({{KW{1'b0}}, {PW{1'b0}}, 5'b00001}));
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Frequency-sweep sequencer for the DDS phase-accumulator block.
- Drives its frequency word K and phase word P from a registered sweep configuration: start/stop/step/dwell.
- Single-shot, sawtooth-repeat or triangle sweeps, with start/abort control and done/wrap status.
- Sits between the host config interface and the DDS core's K/P inputs.

Parameters:
KW, 32, frequency-word width (matches DDS K)
PW, 11, phase-word width (matches DDS P)
DW, 16, dwell-counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config write strobe
cfg_ready  out  1  config accepted when high; equals !busy
cfg_k_start  in  KW  first frequency word
cfg_k_stop  in  KW  last frequency word (inclusive bound)
cfg_k_step  in  KW  increment per step
cfg_dwell  in  DW  cycles each K is held; 0 treated as 1
cfg_mode  in  2  0 single-up, 1 sawtooth-repeat, 2 triangle, 3 reserved (treated as 0)
cfg_phase  in  PW  phase offset applied for the whole sweep
start  in  1  begin sweep (sampled in IDLE only)
abort  in  1  stop immediately
k_out  out  KW  to DDS K
p_out  out  PW  to DDS P
busy  out  1  sweep in progress
done  out  1  one-cycle pulse on single-up completion
wrap  out  1  one-cycle pulse on each sawtooth restart / triangle reversal
err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset:
  - All outputs 0 except cfg_ready=1.
  - Config registers 0.
  - State IDLE.
- Config handshake:
  - Transfer on cfg_valid && cfg_ready; all cfg_* fields captured together.
  - Ignored while busy; held registers are unchanged.
- States: IDLE, UP, DOWN.
- IDLE, start:
  - If k_start > k_stop: err pulses next cycle, state stays IDLE.
  - Otherwise: next cycle k_out=k_start, p_out=phase, busy=1, state UP, dwell counter cleared.
- Dwell:
  - Each k_out value is held exactly max(dwell,1) cycles.
  - The K update occurs on the cycle the counter reaches max(dwell,1)-1.
- Step arithmetic uses KW+1 bits.
  - UP: nxt = k_out + step; invalid if nxt > k_stop or a carry occurs.
  - DOWN: nxt = k_out - step; invalid if nxt < k_start or a borrow occurs.
  - If nxt is valid, k_out <= nxt.
- Invalid-nxt handling:
  - mode 0: state IDLE, busy=0, done=1 for one cycle, k_out holds its final value.
  - mode 1: k_out <= k_start, wrap=1.
  - mode 2: reverse direction with wrap=1; k_out <= the reflected value (k_out - step in UP, k_out + step in DOWN) if that lies within [k_start, k_stop], else k_out is held.
- step==0:
  - mode 0 completes after the first dwell.
  - modes 1/2 hold k_start until abort; wrap still pulses each dwell.
- Abort, from any state:
  - Next cycle: state IDLE, busy=0, k_out=0, p_out=0.
  - No done or wrap pulse.
  - abort beats start in the same cycle.
- start while busy is ignored.
- Reset mid-sweep returns everything to reset values asynchronously.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: DDS_SWEEP_CNT_EN.
- Defined:
  - Adds output sweep_cnt (16 bits).
  - Cleared on accepted start; increments on each wrap or done pulse; saturates at 0xFFFF.
- Undefined:
  - Port and logic absent; all other behaviour is identical.

Decomposition:
- Package dds_pkg holds:
  - KW/PW/DW constants.
  - Sweep-mode enum (MODE_SINGLE, MODE_SAW, MODE_TRI).
  - State enum (ST_IDLE, ST_UP, ST_DOWN).
- One natural sub-module, dds_dwell_timer:
  - Inputs: load value, clear, enable.
  - Output: one-cycle expire pulse.
  - Instantiated once.

Test Plan:
- mode0, start=100, stop=400, step=100, dwell=3:
  - k_out 100x3, 200x3, 300x3, 400x3.
  - Then done pulse, busy=0, k_out stays 400.
- mode1, start=0, stop=250, step=100, dwell=1:
  - k_out 0,100,200,0,100,...
  - wrap high in the cycle k_out returns to 0.
- mode2, start=10, stop=30, step=10, dwell=2:
  - k_out 10,10,20,20,30,30,20,20,10,10,20,...
  - wrap pulses at the 30→20 and 10→20 turns.
- Overflow: mode0, start=0xFFFFFF00, stop=0xFFFFFFFF, step=0x80, dwell=1:
  - k_out FFFFFF00, FFFFFF80, then done.
  - k_out never shows a wrapped small value.
- abort and start asserted together mid-sweep:
  - Next cycle busy=0, k_out=0, p_out=0, no done.
  - Subsequent start restarts from k_start.
- cfg_valid while busy: cfg_ready=0 and the running sweep is unchanged.
- Start after config start=500, stop=100: err pulse, busy stays 0, k_out unchanged.
